prog_mem: RTL and testbench
===========================

# prog_mem

Single-port 32 x 32-bit word memory behind a one-wire serial command interface: one serial input carries read/write frames, one serial output returns read data. The storage array `mem` can be preloaded by the simulation environment through hierarchical access, so program images can be placed in memory before a frame is issued. The block serves as a small program/data store in bring-up and test environments where a pin-minimal memory is needed.

## Interface

- No parameters. Fixed geometry: 32 words (`NWORD`), 32 bits per word, 5-bit word address.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in`  in  1  serial command/data input, sampled on `clk` rising edge.
- `out`  out  1  serial read-data output, registered.
- Storage array is named `mem`, declared as 32 entries of 32 bits, index 0..31, word-addressed, so external hierarchical preload by path `<inst>.mem` works.

## Operation

- States: IDLE, OP, ADDR, WDATA, TURN, RSTART, RDATA.
- IDLE: `out`=0. Sampling `in`=1 is a start bit -> OP; `in`=0 stays IDLE.
- OP: sampled `in` is the opcode, 1=write, 0=read -> ADDR.
- ADDR: 5 address bits, MSB first. After the 5th bit: write -> WDATA, read -> TURN.
- WDATA: 32 data bits, MSB first, shifted into a write register. On the edge sampling bit 0, the full word is written to `mem[addr]` -> IDLE. Partial words are never written.
- TURN: one cycle; `mem[addr]` is loaded into the read shift register -> RSTART.
- RSTART: `out`=1 (response start bit) for one cycle -> RDATA.
- RDATA: `out` shifts 32 bits, MSB first, one per cycle; after bit 0, `out`=0 -> IDLE.
- `in` is ignored from TURN through the end of RDATA.
- Read data is the word value at the TURN edge, including a write that completed in any earlier frame.
- All 32 addresses are valid; no wrap-around or out-of-range case exists.

## Timing

- Edge 0 samples the start bit. Edge 1 samples the opcode. Edges 2-6 sample the address.
- Write: edges 7-38 sample the data. `mem` is updated at edge 38. IDLE samples a new start bit from edge 39.
- Read: TURN load occurs at edge 7.
  - `out`=1 after edge 7.
  - `out`=data[31] after edge 8 through data[0] after edge 39.
  - `out`=0 after edge 40. IDLE samples a new start bit from edge 41.
- Back-to-back frames are allowed with zero idle cycles.
- Reset (`rst_n`=0, any time): state=IDLE, `out`=0, and shift/address registers cleared, all immediately and asynchronously. An in-flight frame is abandoned, and a partial write never reaches `mem`. Operation resumes on the first rising edge after `rst_n` rises.
- `mem` contents on reset are defined under Configuration.

## Configuration

- `MEM_CLEAR_ON_RESET_EN` defined: reset also clears all 32 words of `mem` to 0x00000000.
- Not defined (default): `mem` is not touched by reset. Preloaded or written contents survive reset, and words never written or preloaded read as X in simulation.

## Test plan

- Preload `mem[3]`=0x12345678 hierarchically. Send read frame 1,0,00011 -> `out` shows 1, then 0x12345678 MSB first, then 0.
- Write frame 1,1,11111,0xDEADBEEF, then immediately read address 31 -> 0xDEADBEEF. Then read address 30 -> its previous value unchanged.
- Two back-to-back writes with no idle cycle: addr 0=0xA5A5A5A5, addr 1=0x5A5A5A5A. Read both -> exact values, proving frame boundaries are preserved.
- Assert `rst_n` low at edge 20 of a write to addr 5 (old value 0x0). Then read addr 5 -> 0x0 (without `MEM_CLEAR_ON_RESET_EN`), and `out`=0 during reset.
- During read response, toggle `in` randomly -> response unchanged, and no spurious frame is decoded.
- With `MEM_CLEAR_ON_RESET_EN` defined: preload `mem[7]`=0xFFFFFFFF, pulse reset, read addr 7 -> 0x00000000.

Source files
------------

// File: rtl/prog_mem.sv
// prog_mem: 32 x 32-bit word memory behind a one-wire serial frame interface.
// A frame is: start bit, opcode (1=write, 0=read), 5 address bits MSB first,
// then either 32 write-data bits MSB first, or a turnaround cycle followed by
// a response start bit and 32 read-data bits MSB first on 'out'.
// Optional build macro: MEM_CLEAR_ON_RESET_EN -- when defined, reset also
// clears every word of 'mem' to zero; otherwise 'mem' keeps its contents.
module prog_mem (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic out
);

    localparam int NWORD = 32;

    typedef enum logic [2:0] {
        IDLE,
        OP,
        ADDR,
        WDATA,
        TURN,
        RSTART,
        RDATA
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] mem [0:NWORD-1];

    logic        is_write;
    logic [4:0]  addr;
    logic [4:0]  cnt;
    logic [31:0] wreg;
    logic [31:0] rreg;

    logic        out_nxt;
    logic        mem_we;
    logic [31:0] wdata_full;

    // State register; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode, the next value of the registered output and the write strobe.
    always_comb begin
        state_nxt  = state;
        out_nxt    = 1'b0;
        mem_we     = 1'b0;
        wdata_full = {wreg[30:0], in};
        case (state)
            IDLE: begin
                if (in) begin
                    state_nxt = OP;
                end
            end
            OP: begin
                state_nxt = ADDR;
            end
            ADDR: begin
                if (cnt == 5'd4) begin
                    state_nxt = is_write ? WDATA : TURN;
                end
            end
            WDATA: begin
                if (cnt == 5'd31) begin
                    mem_we    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            TURN: begin
                out_nxt   = 1'b1;
                state_nxt = RSTART;
            end
            RSTART: begin
                out_nxt   = rreg[31];
                state_nxt = RDATA;
            end
            RDATA: begin
                if (cnt == 5'd31) begin
                    out_nxt   = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    out_nxt = rreg[31];
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Frame datapath: opcode, address and write shift-in, read shift-out, bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out      <= 1'b0;
            is_write <= 1'b0;
            addr     <= '0;
            cnt      <= '0;
            wreg     <= '0;
            rreg     <= '0;
        end else begin
            out <= out_nxt;
            case (state)
                IDLE: begin
                    cnt <= '0;
                end
                OP: begin
                    is_write <= in;
                    cnt      <= '0;
                end
                ADDR: begin
                    addr <= {addr[3:0], in};
                    cnt  <= (cnt == 5'd4) ? 5'd0 : cnt + 5'd1;
                end
                WDATA: begin
                    wreg <= wdata_full;
                    cnt  <= cnt + 5'd1;
                end
                TURN: begin
                    rreg <= mem[addr];
                end
                RSTART: begin
                    rreg <= {rreg[30:0], 1'b0};
                    cnt  <= '0;
                end
                RDATA: begin
                    rreg <= {rreg[30:0], 1'b0};
                    cnt  <= cnt + 5'd1;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

`ifdef MEM_CLEAR_ON_RESET_EN
    // Storage write port; reset wipes the whole array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NWORD; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            mem[addr] <= wdata_full;
        end
    end
`else
    // Storage write port; only a complete word ever lands here, and reset leaves contents alone.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr] <= wdata_full;
        end
    end
`endif

endmodule

// File: tb/tb_prog_mem.sv
// tb_prog_mem: directed, table-driven bench for prog_mem, plus hand-written
// sequences for reset during a frame and input noise during a read response.
// Honours MEM_CLEAR_ON_RESET_EN for the reset-related expectations.
module tb_prog_mem;

    logic clk = 1'b0;
    logic rst_n;
    logic in;
    logic out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] data;
    } vec_t;

    vec_t vecs [11];

    prog_mem dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (in),
        .out   (out)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Guard against any hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic b);
        @(negedge clk);
        in = b;
    endtask

    task automatic sendHeader(input logic wr, input logic [4:0] a);
        applyStimulus(1'b1);
        applyStimulus(wr);
        for (int i = 4; i >= 0; i--) begin
            applyStimulus(a[i]);
        end
    endtask

    task automatic writeFrame(input logic [4:0] a, input logic [31:0] d);
        sendHeader(1'b1, a);
        for (int i = 31; i >= 0; i--) begin
            applyStimulus(d[i]);
        end
    endtask

    task automatic readFrame(input logic [4:0] a, input logic [31:0] exp, input bit noisy);
        logic [31:0] got;
        got = '0;
        sendHeader(1'b0, a);
        @(negedge clk);
        in = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        checkOutput("turn_low", {31'b0, out}, 32'd0);
        @(negedge clk);
        in = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        checkOutput("resp_start", {31'b0, out}, 32'd1);
        for (int i = 31; i >= 0; i--) begin
            @(negedge clk);
            got[i] = out;
            in = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        checkOutput("resp_data", got, exp);
        @(negedge clk);
        in = 1'b0;
        checkOutput("resp_stop", {31'b0, out}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 5'd3,  32'h12345678};
        vecs[1]  = '{1'b1, 5'd31, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 5'd31, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 5'd30, 32'h0BADF00D};
        vecs[4]  = '{1'b1, 5'd0,  32'hA5A5A5A5};
        vecs[5]  = '{1'b1, 5'd1,  32'h5A5A5A5A};
        vecs[6]  = '{1'b0, 5'd0,  32'hA5A5A5A5};
        vecs[7]  = '{1'b0, 5'd1,  32'h5A5A5A5A};
        vecs[8]  = '{1'b1, 5'd16, 32'h80000001};
        vecs[9]  = '{1'b0, 5'd16, 32'h80000001};
        vecs[10] = '{1'b0, 5'd3,  32'h12345678};

        rst_n = 1'b0;
        in    = 1'b1;
        #12;
        checkOutput("reset_out", {31'b0, out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        in    = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("idle_out", {31'b0, out}, 32'd0);

        dut.mem[3]  = 32'h12345678;
        dut.mem[5]  = 32'h00000000;
        dut.mem[30] = 32'h0BADF00D;

        $display("[TB] running vector table");
        for (int v = 0; v < 11; v++) begin
            if (vecs[v].wr) begin
                writeFrame(vecs[v].addr, vecs[v].data);
            end else begin
                readFrame(vecs[v].addr, vecs[v].data, 1'b0);
            end
        end

        $display("[TB] read with noisy input during response");
        readFrame(5'd31, 32'hDEADBEEF, 1'b1);
        readFrame(5'd0, 32'hA5A5A5A5, 1'b0);

        $display("[TB] reset during read response");
        sendHeader(1'b0, 5'd31);
        @(negedge clk);
        in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("pre_reset_bit", {31'b0, out}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_out", {31'b0, out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        in    = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("post_reset_idle", {31'b0, out}, 32'd0);

        $display("[TB] reset during write to addr 5");
        sendHeader(1'b1, 5'd5);
        for (int i = 0; i < 13; i++) begin
            applyStimulus(1'b1);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        in    = 1'b1;
        #1;
        checkOutput("wr_reset_out", {31'b0, out}, 32'd0);
        repeat (3) @(negedge clk);
        checkOutput("held_reset_out", {31'b0, out}, 32'd0);
        rst_n = 1'b1;
        in    = 1'b0;
        repeat (2) @(negedge clk);
        readFrame(5'd5, 32'h00000000, 1'b0);
`ifdef MEM_CLEAR_ON_RESET_EN
        readFrame(5'd3, 32'h00000000, 1'b0);
        $display("[TB] clear-on-reset of preloaded word");
        dut.mem[7] = 32'hFFFFFFFF;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        in    = 1'b0;
        @(negedge clk);
        readFrame(5'd7, 32'h00000000, 1'b0);
`else
        readFrame(5'd3, 32'h12345678, 1'b0);
        readFrame(5'd16, 32'h80000001, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
